// File: rtl/obi_bus_responder_pkg.sv
// Shared types for the formal OBI bus responder.
// Holds request/outstanding bundles and the counter width helper.
package obi_bus_responder_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
    } obi_outst_t;

    // Bits needed to hold values 0..max inclusive.
    function automatic int cnt_w(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/obi_resp_fifo.sv
// In-order outstanding-request FIFO for the OBI responder.
// Ports: clock, reset (sync, high), push/push_data, pop,
//        count, full, empty, head (oldest entry).
module obi_resp_fifo
    import obi_bus_responder_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = cnt_w(DEPTH),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  obi_outst_t    push_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output obi_outst_t    head
);

    obi_outst_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= inc(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/obi_bus_responder.sv
// Formal OBI bus environment: legal, bounded, in-order gnt/rvalid.
// Ports: clock, reset, core req/addr/we/be/wdata, solver rand_*;
//        gnt_o, rvalid_o, rdata_o, err_o, proto_err_o (sticky).
// Macro OBI_BUS_RESPONDER_ERR_EN enables error responses.
module obi_bus_responder
    import obi_bus_responder_pkg::*;
#(
    parameter int MAX_OUTSTANDING  = 2,
    parameter int MAX_GNT_STALL    = 4,
    parameter int MAX_RVALID_STALL = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    input  logic        rand_gnt_i,
    input  logic        rand_rvalid_i,
    input  logic [31:0] rand_rdata_i,
    input  logic        rand_err_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        proto_err_o
);

    localparam int CW = cnt_w(MAX_OUTSTANDING);
    localparam int GW = cnt_w(MAX_GNT_STALL);
    localparam int RW = cnt_w(MAX_RVALID_STALL);

    logic [CW-1:0] fifo_count;
    logic          full;
    logic          empty;
    obi_outst_t    head;
    obi_outst_t    push_data;
    logic [GW-1:0] gnt_stall;
    logic [RW-1:0] rv_wait;
    obi_req_t      cur;
    obi_req_t      held;
    logic          pend;
    logic [31:0]   unused_head_addr;

    assign cur       = '{addr: addr_i, we: we_i, be: be_i, wdata: wdata_i};
    assign push_data = '{addr: addr_i, we: we_i};

    // full is registered state, so a same-cycle pop cannot free a slot.
    assign gnt_o = !reset && req_i && !full
                 && (rand_gnt_i || gnt_stall == GW'(MAX_GNT_STALL));

    assign rvalid_o = !reset && fifo_count != '0
                    && (rand_rvalid_i || rv_wait == RW'(MAX_RVALID_STALL));

`ifdef OBI_BUS_RESPONDER_ERR_EN
    assign err_o = rvalid_o && rand_err_i;
`else
    logic unused_rand_err;
    assign unused_rand_err = rand_err_i;
    assign err_o = 1'b0;
`endif

    assign rdata_o = (rvalid_o && !head.we && !err_o) ? rand_rdata_i : '0;
    assign unused_head_addr = head.addr;

    obi_resp_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (gnt_o),
        .push_data (push_data),
        .pop       (rvalid_o),
        .count     (fifo_count),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    // Stall count freezes while full so forced grant waits for space.
    always_ff @(posedge clock) begin
        if (reset || !req_i || gnt_o) begin
            gnt_stall <= '0;
        end else if (!full && gnt_stall != GW'(MAX_GNT_STALL)) begin
            gnt_stall <= gnt_stall + GW'(1);
        end
    end

    // Counts cycles the current head has been visible unanswered.
    always_ff @(posedge clock) begin
        if (reset || rvalid_o || empty) begin
            rv_wait <= '0;
        end else if (rv_wait != RW'(MAX_RVALID_STALL)) begin
            rv_wait <= rv_wait + RW'(1);
        end
    end

    // An ungranted request must be held stable until granted.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend        <= 1'b0;
            held        <= '0;
            proto_err_o <= 1'b0;
        end else begin
            if (pend && (!req_i || cur != held)) begin
                proto_err_o <= 1'b1;
            end
            pend <= req_i && !gnt_o;
            if (req_i && !gnt_o) begin
                held <= cur;
            end
        end
    end

endmodule

// File: tb/tb_obi_bus_responder.sv
// Self-checking bench for obi_bus_responder: directed plan steps
// followed by random traffic against a queue-based reference model.
module tb_obi_bus_responder;

    localparam int MAXO = 2;
    localparam int MAXG = 4;
    localparam int MAXR = 4;
`ifdef OBI_BUS_RESPONDER_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        req_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rand_gnt_i;
    logic        rand_rvalid_i;
    logic [31:0] rand_rdata_i;
    logic        rand_err_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        proto_err_o;

    always #5 clock = ~clock;

    obi_bus_responder #(
        .MAX_OUTSTANDING  (MAXO),
        .MAX_GNT_STALL    (MAXG),
        .MAX_RVALID_STALL (MAXR)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_i         (req_i),
        .addr_i        (addr_i),
        .we_i          (we_i),
        .be_i          (be_i),
        .wdata_i       (wdata_i),
        .rand_gnt_i    (rand_gnt_i),
        .rand_rvalid_i (rand_rvalid_i),
        .rand_rdata_i  (rand_rdata_i),
        .rand_err_i    (rand_err_i),
        .gnt_o         (gnt_o),
        .rvalid_o      (rvalid_o),
        .rdata_o       (rdata_o),
        .err_o         (err_o),
        .proto_err_o   (proto_err_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: queue of outstanding write flags in grant order.
    bit          mq[$];
    int          gstall = 0;
    int          rwait  = 0;
    bit          m_proto = 1'b0;
    bit          pend = 1'b0;
    logic [68:0] held = '0;
    logic        e_gnt;
    logic        e_rv;
    logic        e_err;
    logic [31:0] e_rdata;

    function automatic logic [68:0] cur_req();
        return {addr_i, we_i, be_i, wdata_i};
    endfunction

    function automatic void model_comb();
        e_gnt = !reset && req_i && mq.size() < MAXO
              && (rand_gnt_i || gstall == MAXG);
        e_rv  = !reset && mq.size() != 0
              && (rand_rvalid_i || rwait == MAXR);
        e_err = ERR && e_rv && rand_err_i;
        e_rdata = 32'h0;
        if (e_rv && !e_err && mq[0] == 1'b0) e_rdata = rand_rdata_i;
    endfunction

    function automatic void model_seq();
        int sz;
        sz = mq.size();
        if (reset) begin
            mq.delete();
            gstall = 0;
            rwait = 0;
            m_proto = 1'b0;
            pend = 1'b0;
            return;
        end
        if (pend && (!req_i || cur_req() != held)) m_proto = 1'b1;
        pend = req_i && !e_gnt;
        if (req_i && !e_gnt) held = cur_req();
        if (!req_i || e_gnt) gstall = 0;
        else if (sz < MAXO && gstall < MAXG) gstall++;
        if (e_rv || sz == 0) rwait = 0;
        else if (rwait < MAXR) rwait++;
        if (e_rv) void'(mq.pop_front());
        if (e_gnt) mq.push_back(we_i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check all outputs against the model, then advance one clock.
    task automatic cyc(input string tag);
        #1;
        model_comb();
        chk({tag, ".gnt"}, 32'(gnt_o), 32'(e_gnt));
        chk({tag, ".rvalid"}, 32'(rvalid_o), 32'(e_rv));
        chk({tag, ".rdata"}, rdata_o, e_rdata);
        chk({tag, ".err"}, 32'(err_o), 32'(e_err));
        chk({tag, ".proto"}, 32'(proto_err_o), 32'(m_proto));
        @(posedge clock);
        model_seq();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req_i = 1'b1;
        addr_i = 32'h0;
        we_i = 1'b0;
        be_i = 4'hF;
        wdata_i = 32'h0;
        rand_gnt_i = 1'b1;
        rand_rvalid_i = 1'b1;
        rand_rdata_i = 32'h0;
        rand_err_i = 1'b0;
        @(posedge clock);
        #1;
        // Reset gates everything even with all wishes asserted.
        #1;
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_proto", 32'(proto_err_o), 32'd0);
        cyc("rst");

        // Zero-latency grant, response next cycle.
        reset = 1'b0;
        addr_i = 32'h1000;
        #1;
        chk("t1_gnt", 32'(gnt_o), 32'd1);
        chk("t1_empty_rv", 32'(rvalid_o), 32'd0);
        cyc("t1a");
        req_i = 1'b0;
        rand_rdata_i = 32'hDEADBEEF;
        #1;
        chk("t1_rvalid", 32'(rvalid_o), 32'd1);
        chk("t1_rdata", rdata_o, 32'hDEADBEEF);
        cyc("t1b");

        // Forced grant on the fifth request cycle.
        req_i = 1'b1;
        addr_i = 32'h2000;
        rand_gnt_i = 1'b0;
        rand_rvalid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2_gnt", 32'(gnt_o), (i == 4) ? 32'd1 : 32'd0);
            cyc("t2");
        end
        req_i = 1'b0;
        rand_rvalid_i = 1'b1;
        cyc("t2_drain");

        // Full FIFO blocks grant; forced rvalid; grant after pop.
        req_i = 1'b1;
        rand_gnt_i = 1'b1;
        rand_rvalid_i = 1'b0;
        addr_i = 32'h3000;
        cyc("t3_g1");
        addr_i = 32'h3004;
        cyc("t3_g2");
        addr_i = 32'h3008;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_full_gnt", 32'(gnt_o), 32'd0);
            chk("t3_wait_rv", 32'(rvalid_o), 32'd0);
            cyc("t3_full");
        end
        #1;
        chk("t3_forced_rv", 32'(rvalid_o), 32'd1);
        chk("t3_pop_gnt", 32'(gnt_o), 32'd0);
        cyc("t3_pop");
        #1;
        chk("t3_late_gnt", 32'(gnt_o), 32'd1);
        cyc("t3_g3");
        req_i = 1'b0;
        rand_rvalid_i = 1'b1;
        cyc("t3_d1");
        cyc("t3_d2");

        // Write then read, answered in order.
        req_i = 1'b1;
        rand_rvalid_i = 1'b0;
        addr_i = 32'h100;
        we_i = 1'b1;
        wdata_i = 32'h55AA55AA;
        cyc("t4_wr");
        addr_i = 32'h104;
        we_i = 1'b0;
        cyc("t4_rd");
        req_i = 1'b0;
        rand_rvalid_i = 1'b1;
        rand_rdata_i = 32'hCAFEF00D;
        #1;
        chk("t4_wr_rdata", rdata_o, 32'd0);
        cyc("t4_r1");
        #1;
        chk("t4_rd_rdata", rdata_o, 32'hCAFEF00D);
        cyc("t4_r2");

        // Error response.
        req_i = 1'b1;
        rand_rvalid_i = 1'b0;
        addr_i = 32'h400;
        cyc("t5_req");
        req_i = 1'b0;
        rand_rvalid_i = 1'b1;
        rand_err_i = 1'b1;
        rand_rdata_i = 32'h12345678;
        #1;
        chk("t5_err", 32'(err_o), 32'(ERR));
        chk("t5_rdata", rdata_o, ERR ? 32'd0 : 32'h12345678);
        cyc("t5_rsp");
        rand_err_i = 1'b0;

        // Address changes while ungranted.
        chk("t6_pre", 32'(proto_err_o), 32'd0);
        req_i = 1'b1;
        rand_gnt_i = 1'b0;
        addr_i = 32'h200;
        cyc("t6_a");
        addr_i = 32'h204;
        cyc("t6_b");
        req_i = 1'b0;
        chk("t6_set", 32'(proto_err_o), 32'd1);
        cyc("t6_c");
        cyc("t6_d");
        chk("t6_sticky", 32'(proto_err_o), 32'd1);
        reset = 1'b1;
        cyc("t6_rst");
        reset = 1'b0;
        chk("t6_clr", 32'(proto_err_o), 32'd0);

        // Random legal traffic with occasional reset.
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            if (!pend) begin
                req_i = $urandom_range(0, 2) != 0;
                addr_i = $urandom;
                we_i = $urandom_range(0, 1) == 1;
                be_i = 4'($urandom);
                wdata_i = $urandom;
            end
            rand_gnt_i = $urandom_range(0, 2) == 0;
            rand_rvalid_i = $urandom_range(0, 3) == 0;
            rand_rdata_i = $urandom;
            rand_err_i = $urandom_range(0, 1) == 1;
            cyc("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
